// File: rtl/ap_ctrl_chain_driver.sv
// rtl/ap_ctrl_chain_driver.sv - ap_ctrl_chain initiator with latency measurement
//
// Drives a kernel through the ap_start/ap_ready/ap_done/ap_continue handshake for a
// commanded number of transactions. ap_continue can be held off by a programmable
// number of cycles after ap_done. Each issue pushes a cycle timestamp into a small
// FIFO; each completion pops it to measure start->done latency.
//
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         run command handshake (ready only in IDLE)
//   cmd_count, cmd_cont_delay   transactions to run, ap_continue hold-off cycles
//   ap_start/ap_ready           issue handshake toward the kernel
//   ap_done/ap_continue         completion handshake from the kernel
//   busy, done, err             RUN indicator, end-of-run pulse, sticky spurious-done flag
//   issued_cnt, completed_cnt   per-run transaction counters
//   last_latency, max_latency   per-run latency results
module ap_ctrl_chain_driver #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned DLY_W = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [DLY_W-1:0] cmd_cont_delay,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] completed_cnt,
   output logic [CNT_W-1:0] last_latency,
   output logic [CNT_W-1:0] max_latency
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DLY_W-1:0] delay_q, delay_d;
   logic [DLY_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] completed_q, completed_d;
   logic [CNT_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic             err_q, err_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] fifo_q [DEPTH];
   logic [CNT_W-1:0] fifo_d [DEPTH];

   logic             in_run;
   logic             fifo_full;
   logic             fifo_empty;
   logic             issue;
   logic             complete;
   logic             spurious;
   logic [CNT_W-1:0] latency;

   assign in_run     = (state_q == ST_RUN);
   assign fifo_full  = (occ_q == OCC_W'(DEPTH));
   assign fifo_empty = (occ_q == '0);

   // Start gating uses only registered occupancy, so a pop in the same cycle
   // frees the slot for the following cycle, not this one.
   assign ap_start    = in_run && (issued_q < count_q) && !fifo_full;
   assign ap_continue = in_run && ap_done && (stall_q >= delay_q);

   assign issue    = ap_start && ap_ready;
   assign complete = ap_continue && !fifo_empty;
   assign spurious = in_run && ap_done && fifo_empty;

   // Modular subtraction keeps the result correct when cyc wraps.
   assign latency = cyc_q - fifo_q[rd_ptr_q];

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = in_run;
   assign done          = (state_q == ST_REPORT);
   assign err           = err_q;
   assign issued_cnt    = issued_q;
   assign completed_cnt = completed_q;
   assign last_latency  = last_q;
   assign max_latency   = max_q;

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q + CNT_W'(1);
      count_d     = count_q;
      delay_d     = delay_q;
      stall_d     = stall_q;
      issued_d    = issued_q;
      completed_d = completed_q;
      last_d      = last_q;
      max_d       = max_q;
      err_d       = err_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      fifo_d      = fifo_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               count_d     = cmd_count;
               delay_d     = cmd_cont_delay;
               stall_d     = '0;
               issued_d    = '0;
               completed_d = '0;
               last_d      = '0;
               max_d       = '0;
               err_d       = 1'b0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               occ_d       = '0;
               state_d     = ST_RUN;
            end
         end

         ST_RUN: begin
            if (issue) begin
               fifo_d[wr_ptr_q] = cyc_q;
               wr_ptr_d         = wr_ptr_q + PTR_W'(1);
               issued_d         = issued_q + CNT_W'(1);
            end

            if (complete) begin
               rd_ptr_d    = rd_ptr_q + PTR_W'(1);
               last_d      = latency;
               completed_d = completed_q + CNT_W'(1);
               stall_d     = '0;
               if (latency > max_q) begin
                  max_d = latency;
               end
            end else if (ap_done && !ap_continue && (stall_q != '1)) begin
               stall_d = stall_q + DLY_W'(1);
            end

            if (spurious) begin
               err_d = 1'b1;
            end

            // Push and pop in the same cycle leave occupancy unchanged.
            case ({issue, complete})
               2'b10:   occ_d = occ_q + OCC_W'(1);
               2'b01:   occ_d = occ_q - OCC_W'(1);
               default: occ_d = occ_q;
            endcase

            if (completed_q == count_q) begin
               state_d = ST_REPORT;
            end
         end

         ST_REPORT: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cyc_q       <= '0;
         count_q     <= '0;
         delay_q     <= '0;
         stall_q     <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         last_q      <= '0;
         max_q       <= '0;
         err_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         count_q     <= count_d;
         delay_q     <= delay_d;
         stall_q     <= stall_d;
         issued_q    <= issued_d;
         completed_q <= completed_d;
         last_q      <= last_d;
         max_q       <= max_d;
         err_q       <= err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         fifo_q      <= fifo_d;
      end
   end

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// tb/tb_ap_ctrl_chain_driver.sv - self-checking bench for ap_ctrl_chain_driver
module tb_ap_ctrl_chain_driver;

   localparam int CNT_W = 32;
   localparam int DLY_W = 8;
   localparam int DEPTH = 4;

   logic             clock;
   logic             reset_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_count;
   logic [DLY_W-1:0] cmd_cont_delay;
   logic             ap_start;
   logic             ap_ready;
   logic             ap_done;
   logic             ap_continue;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] issued_cnt;
   logic [CNT_W-1:0] completed_cnt;
   logic [CNT_W-1:0] last_latency;
   logic [CNT_W-1:0] max_latency;

   int checks   = 0;
   int failures = 0;

   ap_ctrl_chain_driver #(
      .CNT_W(CNT_W),
      .DLY_W(DLY_W),
      .DEPTH(DEPTH)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_count     (cmd_count),
      .cmd_cont_delay(cmd_cont_delay),
      .ap_start      (ap_start),
      .ap_ready      (ap_ready),
      .ap_done       (ap_done),
      .ap_continue   (ap_continue),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .issued_cnt    (issued_cnt),
      .completed_cnt (completed_cnt),
      .last_latency  (last_latency),
      .max_latency   (max_latency)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // One run: command fields, kernel behaviour (ready after rl cycles of ap_start,
   // done dl cycles after issue, done withheld before cycle hold), expected results.
   // Cycle numbers count from the first RUN cycle.
   typedef struct {
      int count;
      int delay;
      int rl;
      int dl;
      int hold;
      bit wrap;
      int exp_issued;
      int exp_completed;
      int exp_last;
      int exp_max;
      int exp_done_cyc;
      int exp_start_cycles;
      int lo_cyc;
      int hi_cyc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int wait_n;
      int due_q[$];
      int done_cyc;
      int start_cycles;
      wait_n       = 0;
      done_cyc     = -1;
      start_cycles = 0;

      @(negedge clock);
      chk($sformatf("r%0d_cmd_ready", idx), cmd_ready, 1);
      cmd_valid      = 1'b1;
      cmd_count      = CNT_W'(v.count);
      cmd_cont_delay = DLY_W'(v.delay);
      @(negedge clock);
      cmd_valid = 1'b0;

      for (int cyc = 0; cyc < 300; cyc++) begin
         if (v.wrap && cyc == 0) begin
            force dut.cyc_q = 32'hFFFF_FFFE;
            #1;
            release dut.cyc_q;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == 0) chk($sformatf("r%0d_busy", idx), busy, 1);
         ap_ready = ap_start && (wait_n >= v.rl);
         ap_done  = (due_q.size() > 0) && (due_q[0] <= cyc) && (cyc >= v.hold);
         #1;
         if (ap_start) start_cycles++;
         if (cyc == v.lo_cyc) chk($sformatf("r%0d_start_blocked", idx), ap_start, 0);
         if (cyc == v.hi_cyc) chk($sformatf("r%0d_start_resumed", idx), ap_start, 1);
         if (ap_start && ap_ready) begin
            due_q.push_back(cyc + v.dl);
            wait_n = 0;
         end else if (ap_start) begin
            wait_n++;
         end
         if (ap_done && ap_continue) void'(due_q.pop_front());
         @(negedge clock);
      end
      ap_ready = 1'b0;
      ap_done  = 1'b0;

      chk($sformatf("r%0d_done_cycle", idx), done_cyc, v.exp_done_cyc);
      chk($sformatf("r%0d_issued", idx), issued_cnt, v.exp_issued);
      chk($sformatf("r%0d_completed", idx), completed_cnt, v.exp_completed);
      chk($sformatf("r%0d_last_latency", idx), last_latency, v.exp_last);
      chk($sformatf("r%0d_max_latency", idx), max_latency, v.exp_max);
      chk($sformatf("r%0d_err", idx), err, 0);
      chk($sformatf("r%0d_start_cycles", idx), start_cycles, v.exp_start_cycles);

      @(negedge clock);
      chk($sformatf("r%0d_done_pulse_end", idx), done, 0);
      chk($sformatf("r%0d_idle_ready", idx), cmd_ready, 1);
      chk($sformatf("r%0d_idle_busy", idx), busy, 0);
      chk($sformatf("r%0d_hold_completed", idx), completed_cnt, v.exp_completed);
      chk($sformatf("r%0d_hold_max", idx), max_latency, v.exp_max);
   endtask

   initial begin
      //          cnt dly rl dl hold wrap iss cmp last max dcyc starts lo  hi
      vecs[0] = '{3,  0,  1, 5, 0,   0,   3,  3,  5,   5,  12,  6,     -1, -1};
      vecs[1] = '{1,  4,  1, 5, 0,   0,   1,  1,  9,   9,  12,  2,     -1, -1};
      vecs[2] = '{0,  0,  0, 0, 0,   0,   0,  0,  0,   0,  1,   0,     -1, -1};
      vecs[3] = '{2,  2,  0, 1, 0,   0,   2,  2,  5,   5,  8,   2,     -1, -1};
      vecs[4] = '{8,  0,  0, 1, 10,  0,   8,  8,  3,   10, 19,  8,     10, 11};
      vecs[5] = '{1,  0,  0, 5, 0,   1,   1,  1,  5,   5,  7,   1,     -1, -1};

      reset_n        = 1'b0;
      cmd_valid      = 1'b0;
      cmd_count      = '0;
      cmd_cont_delay = '0;
      ap_ready       = 1'b0;
      ap_done        = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ap_start", ap_start, 0);
      chk("rst_ap_continue", ap_continue, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_issued", issued_cnt, 0);
      chk("rst_max", max_latency, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // ap_done while IDLE is ignored.
      ap_done = 1'b1;
      #1;
      chk("idle_done_no_continue", ap_continue, 0);
      @(negedge clock);
      chk("idle_done_no_err", err, 0);
      ap_done = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_vec(i, vecs[i]);
      end

      // Spurious ap_done with nothing outstanding, then reset mid-run.
      @(negedge clock);
      cmd_valid      = 1'b1;
      cmd_count      = CNT_W'(1);
      cmd_cont_delay = '0;
      @(negedge clock);
      cmd_valid = 1'b0;
      chk("spur_start_high", ap_start, 1);
      ap_done = 1'b1;
      #1;
      chk("spur_continue", ap_continue, 1);
      @(negedge clock);
      ap_done = 1'b0;
      chk("spur_err_set", err, 1);
      chk("spur_no_complete", completed_cnt, 0);
      @(negedge clock);
      chk("spur_err_sticky", err, 1);
      chk("spur_still_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ap_start", ap_start, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_issued", issued_cnt, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_err", err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
